shift_add_multiplier: RTL



---
 rtl/arith_pkg.sv | 21 ++
 rtl/RC_adder.sv | 29 ++
 rtl/shift_add_multiplier.sv | 97 +++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: shared widths and state encoding for the shift-and-add multiplier
// and the ripple-carry adder it iterates.
//   OPW    - operand width of the adder and multiplier inputs
//   PRODW  - width of the multiplier product
//   ST_*   - state encoding. The spare code 2'd3 is illegal and recovers to IDLE.
package arith_pkg;

  localparam int OPW   = 4;
  localparam int PRODW = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/RC_adder.sv
// RC_adder: 4-bit combinational ripple-carry adder.
// Ports:
//   A, B     in  OPW  addends
//   C_in     in  1    carry into bit 0
//   Sum_out  out OPW  sum bits
//   C_out    out 1    carry out of the top bit
module RC_adder
  import arith_pkg::*;
(
  input  logic [OPW-1:0] A,
  input  logic [OPW-1:0] B,
  input  logic           C_in,
  output logic [OPW-1:0] Sum_out,
  output logic           C_out
);

  logic [OPW:0] carry;

  assign carry[0] = C_in;

  // One full adder per bit. The carry ripples from bit 0 upward.
  for (genvar i = 0; i < OPW; i++) begin : g_fa
    assign Sum_out[i]  = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1]  = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign C_out = carry[OPW];

endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential 4x4 unsigned multiplier. It reuses one
// RC_adder instance per cycle in shift-and-add fashion.
// Ports:
//   clk          in  1      rising-edge clock
//   rst_n        in  1      asynchronous active-low reset
//   Start        in  1      request; sampled only while idle
//   Data_in_A    in  OPW    multiplicand; captured on the accepting edge
//   Data_in_B    in  OPW    multiplier; captured on the accepting edge
//   Busy         out 1      high from acceptance through the DONE cycle
//   Done         out 1      one-cycle pulse when Product_out is updated
//   Product_out  out PRODW  registered product; held until the next completion
module shift_add_multiplier
  import arith_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [OPW-1:0]   Data_in_A,
  input  logic [OPW-1:0]   Data_in_B,
  output logic             Busy,
  output logic             Done,
  output logic [PRODW-1:0] Product_out
);

  state_t           state;
  logic [OPW-1:0]   m;
  logic [PRODW:0]   p;     // {carry, hi, lo}
  logic [1:0]       cnt;

  logic [OPW-1:0]   add_b;
  logic [OPW-1:0]   sum;
  logic             c_out;
  logic [PRODW-1:0] shifted;

  // Add the multiplicand only when the current multiplier bit is set.
  assign add_b = p[0] ? m : '0;

  // p[8] is always zero during CALC because a zero is shifted into it on
  // every update. Feeding it to the carry-in gives the required zero
  // carry and keeps every register bit in use.
  RC_adder u_adder (
    .A       (p[7:4]),
    .B       (add_b),
    .C_in    (p[PRODW]),
    .Sum_out (sum),
    .C_out   (c_out)
  );

  // Logical shift right of {C_out, Sum_out, lo}. The carry is kept, so no
  // partial-product bit is lost.
  assign shifted = {c_out, sum, p[3:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      m           <= '0;
      p           <= '0;
      cnt         <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Product_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            m     <= Data_in_A;
            p     <= {{(PRODW-OPW+1){1'b0}}, Data_in_B};
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          p   <= {1'b0, shifted};
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            Product_out <= shifted;
            Done        <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
